// File: rtl/debounce_edge.sv
// Synchronizes and debounces an asynchronous level input, producing a filtered
// level, one-cycle rise/fall pulses and a wrapping count of accepted changes.
module debounce_edge #(
  parameter int SYNC_STAGES     = 2,
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       d_i,
  output logic       level_o,
  output logic       rise_o,
  output logic       fall_o,
  output logic [7:0] edge_cnt_o
);

  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] CNT_LAST = CW'(DEBOUNCE_CYCLES - 1);

  logic [SYNC_STAGES-1:0] sync_q, sync_d;
  logic                   sync;
  logic [CW-1:0]          cnt_q, cnt_d;
  logic                   level_q, level_d;
  logic                   rise_q, rise_d;
  logic                   fall_q, fall_d;
  logic [7:0]             edge_cnt_q, edge_cnt_d;

  // Plain flop chain, nothing between stages, to keep metastability contained.
  assign sync_d[0] = d_i;
  generate
    for (genvar gi = 1; gi < SYNC_STAGES; gi++) begin : g_sync
      assign sync_d[gi] = sync_q[gi-1];
    end
  endgenerate

  assign sync = sync_q[SYNC_STAGES-1];

  always_comb begin
    cnt_d      = '0;
    level_d    = level_q;
    rise_d     = 1'b0;
    fall_d     = 1'b0;
    edge_cnt_d = edge_cnt_q;
    if (sync != level_q) begin
      if (cnt_q == CNT_LAST) begin
        // New value has persisted long enough: accept it and restart the count.
        level_d    = sync;
        rise_d     = sync;
        fall_d     = ~sync;
        edge_cnt_d = edge_cnt_q + 8'd1;
      end else if (cnt_q < CNT_LAST) begin
        cnt_d = cnt_q + CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sync_q     <= '0;
      cnt_q      <= '0;
      level_q    <= 1'b0;
      rise_q     <= 1'b0;
      fall_q     <= 1'b0;
      edge_cnt_q <= 8'd0;
    end else begin
      sync_q     <= sync_d;
      cnt_q      <= cnt_d;
      level_q    <= level_d;
      rise_q     <= rise_d;
      fall_q     <= fall_d;
      edge_cnt_q <= edge_cnt_d;
    end
  end

  assign level_o    = level_q;
  assign rise_o     = rise_q;
  assign fall_o     = fall_q;
  assign edge_cnt_o = edge_cnt_q;

endmodule

// File: tb/tb_debounce_edge.sv
// Directed and randomized checks of debounce_edge: a default instance and a
// single-cycle-debounce instance for the counter wrap scenario.
module tb_debounce_edge;

  logic       clk = 1'b0;
  logic       reset_a, d_a, reset_b, d_b;
  logic       level_a, rise_a, fall_a, level_b, rise_b, fall_b;
  logic [7:0] cnt_a, cnt_b;
  int         n_cmp = 0;
  int         n_err = 0;

  always #5 clk = ~clk;

  debounce_edge u_a (
    .clk(clk), .reset(reset_a), .d_i(d_a),
    .level_o(level_a), .rise_o(rise_a), .fall_o(fall_a), .edge_cnt_o(cnt_a)
  );

  debounce_edge #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(1)) u_b (
    .clk(clk), .reset(reset_b), .d_i(d_b),
    .level_o(level_b), .rise_o(rise_b), .fall_o(fall_b), .edge_cnt_o(cnt_b)
  );

  // Outputs are observed 1 time unit after each rising edge.
  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    logic [10:0] exp_v;
    reset_a = 1'b1;
    d_a     = 1'b0;
    repeat (3) tick();
    reset_a = 1'b0;
    exp_v   = 11'd0;
    for (int c = 0; c < 20; c++) begin
      tick();
      n_cmp++;
      if ({level_a, rise_a, fall_a, cnt_a} !== exp_v) begin
        n_err++;
        $display("FAIL reset_idle cycle %0d: got %b want %b", c, {level_a, rise_a, fall_a, cnt_a}, exp_v);
      end
    end
    $display("test_reset: 20 idle cycles checked");
  endtask

  // First sample at edge 0; acceptance lands on edge 5 with the default parameters.
  task automatic test_rise_fall();
    logic [10:0] exp_v;
    for (int dir = 0; dir < 2; dir++) begin
      d_a = (dir == 0);
      for (int e = 0; e <= 6; e++) begin
        tick();
        if (dir == 0)
          exp_v = (e < 5) ? {3'b000, 8'd0} : (e == 5) ? {3'b110, 8'd1} : {3'b100, 8'd1};
        else
          exp_v = (e < 5) ? {3'b100, 8'd1} : (e == 5) ? {3'b001, 8'd2} : {3'b000, 8'd2};
        n_cmp++;
        if ({level_a, rise_a, fall_a, cnt_a} !== exp_v) begin
          n_err++;
          $display("FAIL rise_fall dir %0d edge %0d: got %b want %b", dir, e, {level_a, rise_a, fall_a, cnt_a}, exp_v);
        end
      end
      $display("test_rise_fall: direction %0d accepted, edge_cnt %0d", dir, cnt_a);
    end
  endtask

  task automatic test_glitch();
    logic [10:0] exp_v;
    exp_v = {3'b000, 8'd2};
    for (int r = 0; r < 5; r++) begin
      for (int c = 0; c < 8; c++) begin
        d_a = (c < 3);
        tick();
        n_cmp++;
        if ({level_a, rise_a, fall_a, cnt_a} !== exp_v) begin
          n_err++;
          $display("FAIL glitch rep %0d cycle %0d: got %b want %b", r, c, {level_a, rise_a, fall_a, cnt_a}, exp_v);
        end
      end
      $display("test_glitch: 3-cycle pulse %0d rejected", r);
    end
  endtask

  // Reset lands on the edge where the acceptance would otherwise occur.
  task automatic test_reset_mid();
    logic [10:0] exp_v;
    d_a = 1'b1;
    for (int e = 0; e < 5; e++) begin
      tick();
      exp_v = {3'b000, 8'd2};
      n_cmp++;
      if ({level_a, rise_a, fall_a, cnt_a} !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid pre edge %0d: got %b want %b", e, {level_a, rise_a, fall_a, cnt_a}, exp_v);
      end
    end
    reset_a = 1'b1;
    tick();
    reset_a = 1'b0;
    exp_v = 11'd0;
    n_cmp++;
    if ({level_a, rise_a, fall_a, cnt_a} !== exp_v) begin
      n_err++;
      $display("FAIL reset_mid at_reset: got %b want %b", {level_a, rise_a, fall_a, cnt_a}, exp_v);
    end
    for (int e = 0; e <= 6; e++) begin
      tick();
      exp_v = (e < 5) ? 11'd0 : (e == 5) ? {3'b110, 8'd1} : {3'b100, 8'd1};
      n_cmp++;
      if ({level_a, rise_a, fall_a, cnt_a} !== exp_v) begin
        n_err++;
        $display("FAIL reset_mid post edge %0d: got %b want %b", e, {level_a, rise_a, fall_a, cnt_a}, exp_v);
      end
    end
    $display("test_reset_mid: partial count discarded, edge_cnt %0d", cnt_a);
  endtask

  // Single-cycle debounce: each toggle is accepted on the third edge after it is driven.
  task automatic test_wrap();
    logic [10:0] exp_v;
    logic        lvl;
    logic [7:0]  cnt;
    reset_b = 1'b0;
    lvl = 1'b0;
    cnt = 8'd0;
    for (int t = 1; t <= 256; t++) begin
      d_b = ~lvl;
      for (int e = 0; e < 4; e++) begin
        tick();
        if (e == 2) begin
          lvl = ~lvl;
          cnt = cnt + 8'd1;
          exp_v = {lvl, lvl, ~lvl, cnt};
        end else begin
          exp_v = {lvl, 2'b00, cnt};
        end
        n_cmp++;
        if ({level_b, rise_b, fall_b, cnt_b} !== exp_v || (rise_b && fall_b)) begin
          n_err++;
          $display("FAIL wrap toggle %0d edge %0d: got %b want %b", t, e, {level_b, rise_b, fall_b, cnt_b}, exp_v);
        end
      end
      if (t >= 254) $display("test_wrap: toggle %0d edge_cnt %0d", t, cnt_b);
    end
  endtask

  // Reference: an acceptance happens when the last DEBOUNCE_CYCLES synchronized
  // values seen by the filter all differ from the current level.
  task automatic test_random();
    logic        s0, s1, used, m_lvl, m_rise, m_fall, cur_d, cur_r;
    logic [3:0]  win;
    logic [7:0]  m_cnt;
    logic [10:0] exp_v;
    int          hold, errs_before;
    s0 = 0; s1 = 0; win = '0; m_lvl = 0; m_rise = 0; m_fall = 0; m_cnt = 0;
    hold = 0;
    errs_before = n_err;
    for (int c = 0; c < 700; c++) begin
      reset_a = (c < 2) || (c == 350);
      if (hold == 0) begin
        d_a  = 1'($urandom_range(0, 1));
        hold = $urandom_range(1, 10);
      end
      hold--;
      cur_d = d_a;
      cur_r = reset_a;
      tick();
      if (cur_r) begin
        s0 = 0; s1 = 0; win = '0; m_lvl = 0; m_rise = 0; m_fall = 0; m_cnt = 0;
      end else begin
        used   = s1;
        s1     = s0;
        s0     = cur_d;
        win    = {win[2:0], used};
        m_rise = 1'b0;
        m_fall = 1'b0;
        if (win == {4{~m_lvl}}) begin
          m_rise = ~m_lvl;
          m_fall = m_lvl;
          m_lvl  = ~m_lvl;
          m_cnt  = m_cnt + 8'd1;
        end
      end
      exp_v = {m_lvl, m_rise, m_fall, m_cnt};
      n_cmp++;
      if ({level_a, rise_a, fall_a, cnt_a} !== exp_v || (rise_a && fall_a)) begin
        n_err++;
        $display("FAIL random cycle %0d: got %b want %b", c, {level_a, rise_a, fall_a, cnt_a}, exp_v);
      end
    end
    reset_a = 1'b0;
    $display("test_random: 700 cycles, %0d model edges, %0d new errors", m_cnt, n_err - errs_before);
  endtask

  initial begin
    reset_a = 1'b1;
    d_a     = 1'b0;
    reset_b = 1'b1;
    d_b     = 1'b0;
    test_reset();
    test_rise_fall();
    test_glitch();
    test_reset_mid();
    test_wrap();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
